// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier: one iteration per clock, start/busy/done.
// Define SEQ_MULT_SIGNED_EN to add a two's-complement signed_mode input.
module seq_shift_add_mult #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
`ifdef SEQ_MULT_SIGNED_EN
   input  logic               signed_mode,
`endif
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [2*WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic               sgn_q;
   logic               accept;
   logic               last;
   logic [WIDTH:0]     upper;
   logic [WIDTH:0]     mext;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH:0]   shifted;

   assign accept = start && (state_q != RUN);

`ifdef SEQ_MULT_SIGNED_EN
   logic sgn_d;

   always_comb begin
      sgn_d = sgn_q;
      if (accept) begin
         sgn_d = signed_mode;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sgn_q <= 1'b0;
      end else begin
         sgn_q <= sgn_d;
      end
   end
`else
   assign sgn_q = 1'b0;
`endif

   // Signed mode: the multiplier MSB has negative weight, so the last step subtracts.
   always_comb begin
      last  = (cnt_q == CW'(1));
      upper = acc_q[2*WIDTH:WIDTH];
      mext  = {sgn_q & mcand_q[WIDTH-1], mcand_q};
      sum   = upper;
      if (acc_q[0]) begin
         if (sgn_q && last) begin
            sum = upper - mext;
         end else begin
            sum = upper + mext;
         end
      end
      shifted = {sgn_q & sum[WIDTH], sum, acc_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               state_d = RUN;
               mcand_d = a;
               acc_d   = {{(WIDTH + 1){1'b0}}, b};
               cnt_d   = CW'(WIDTH);
            end
         end
         RUN: begin
            acc_d = shifted;
            cnt_d = cnt_q - CW'(1);
            if (last) begin
               product_d = shifted[2*WIDTH-1:0];
               state_d   = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult at WIDTH=4 and WIDTH=16.
// Signed-mode vectors are exercised when SEQ_MULT_SIGNED_EN is defined.
module tb_seq_shift_add_mult;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start4;
   logic [3:0]  a4, b4;
   logic        busy4, done4;
   logic [7:0]  prod4;
   logic        start16;
   logic [15:0] a16, b16;
   logic        busy16, done16;
   logic [31:0] prod16;
`ifdef SEQ_MULT_SIGNED_EN
   logic        sm4;
   logic        sm16;
`endif
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   seq_shift_add_mult #(.WIDTH(4)) u4 (
      .clk(clk),
      .rst_n(rst_n),
      .start(start4),
`ifdef SEQ_MULT_SIGNED_EN
      .signed_mode(sm4),
`endif
      .a(a4),
      .b(b4),
      .busy(busy4),
      .done(done4),
      .product(prod4)
   );

   seq_shift_add_mult #(.WIDTH(16)) u16 (
      .clk(clk),
      .rst_n(rst_n),
      .start(start16),
`ifdef SEQ_MULT_SIGNED_EN
      .signed_mode(sm16),
`endif
      .a(a16),
      .b(b16),
      .busy(busy16),
      .done(done16),
      .product(prod16)
   );

   task automatic do_mul4(input logic [3:0] x, input logic [3:0] y,
                          output int n);
      a4 = x;
      b4 = y;
      start4 = 1'b1;
      n = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) start4 = 1'b0;
         if (done4) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic do_mul16(input logic [15:0] x, input logic [15:0] y,
                           output int n);
      a16 = x;
      b16 = y;
      start16 = 1'b1;
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) start16 = 1'b0;
         if (done16) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int bc;
      rst_n = 1'b0;
      #1;
      tests++;
      if (busy4 !== 1'b0 || done4 !== 1'b0 || prod4 !== 8'h00) begin
         fails++;
         $display("FAIL reset_w4: busy=%b done=%b prod=%h want 0 0 00",
                  busy4, done4, prod4);
      end
      tests++;
      if (busy16 !== 1'b0 || done16 !== 1'b0 || prod16 !== 32'h0) begin
         fails++;
         $display("FAIL reset_w16: busy=%b done=%b prod=%h want 0 0 0",
                  busy16, done16, prod16);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      a4 = 4'd15;
      b4 = 4'd15;
      start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      tests++;
      if (busy4 !== 1'b1) begin
         fails++;
         $display("FAIL first_start: busy=%b want 1", busy4);
      end
      bc = 1;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (busy4 === 1'b1 && done4 === 1'b0) bc++;
      end
      tests++;
      if (bc != 4) begin
         fails++;
         $display("FAIL busy_len: busy cycles=%0d want 4", bc);
      end
      @(posedge clk);
      #1;
      tests++;
      if (done4 !== 1'b1 || busy4 !== 1'b0 || prod4 !== 8'hE1) begin
         fails++;
         $display("FAIL done_15x15: done=%b busy=%b prod=%h want 1 0 e1",
                  done4, busy4, prod4);
      end
      @(posedge clk);
      #1;
      tests++;
      if (done4 !== 1'b0 || prod4 !== 8'hE1) begin
         fails++;
         $display("FAIL done_pulse: done=%b prod=%h want 0 e1", done4, prod4);
      end
   endtask

   task automatic test_exhaustive();
      int n;
      logic [3:0] x, y;
      logic [7:0] exp_p;
      for (int i = 0; i < 256; i++) begin
         x = i[7:4];
         y = i[3:0];
         exp_p = {4'b0, x} * {4'b0, y};
         do_mul4(x, y, n);
         tests++;
         if (prod4 !== exp_p) begin
            fails++;
            $display("FAIL exh_prod %0d*%0d: got %h want %h", x, y, prod4, exp_p);
         end
         tests++;
         if (n != 5) begin
            fails++;
            $display("FAIL exh_rate %0d*%0d: got %0d cycles want 5", x, y, n);
         end
      end
   endtask

   task automatic test_busy_start();
      int dc;
      logic [7:0] p;
      @(posedge clk);
      #1;
      a4 = 4'd3;
      b4 = 4'd5;
      start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      @(posedge clk);
      #1;
      a4 = 4'd9;
      b4 = 4'd9;
      start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      tests++;
      if (busy4 !== 1'b1) begin
         fails++;
         $display("FAIL busy_mid: busy=%b want 1", busy4);
      end
      dc = 0;
      p = 8'h00;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (done4 === 1'b1) begin
            dc++;
            p = prod4;
         end
      end
      tests++;
      if (dc != 1) begin
         fails++;
         $display("FAIL busy_ignore_pulses: got %0d want 1", dc);
      end
      tests++;
      if (p !== 8'd15 || prod4 !== 8'd15) begin
         fails++;
         $display("FAIL busy_ignore_prod: got %h/%h want 0f", p, prod4);
      end
   endtask

   task automatic test_reset_mid();
      int dc, n;
      a4 = 4'd7;
      b4 = 4'd6;
      start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      tests++;
      if (busy4 !== 1'b1) begin
         fails++;
         $display("FAIL rst_mid_pre: busy=%b want 1", busy4);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (busy4 !== 1'b0 || done4 !== 1'b0 || prod4 !== 8'h00) begin
         fails++;
         $display("FAIL rst_mid_async: busy=%b done=%b prod=%h want 0 0 00",
                  busy4, done4, prod4);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      dc = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (done4 === 1'b1) dc++;
      end
      tests++;
      if (dc != 0) begin
         fails++;
         $display("FAIL rst_mid_nodone: got %0d pulses want 0", dc);
      end
      do_mul4(4'd2, 4'd3, n);
      tests++;
      if (prod4 !== 8'd6 || n != 5) begin
         fails++;
         $display("FAIL rst_mid_after: prod=%h cycles=%0d want 06 5", prod4, n);
      end
   endtask

   task automatic test_w16();
      int n;
      do_mul16(16'hFFFF, 16'hFFFF, n);
      tests++;
      if (prod16 !== 32'hFFFE0001) begin
         fails++;
         $display("FAIL w16_max: got %h want fffe0001", prod16);
      end
      tests++;
      if (n != 17) begin
         fails++;
         $display("FAIL w16_lat: got %0d cycles want 17", n);
      end
      a16 = 16'h0000;
      b16 = 16'h1234;
      start16 = 1'b1;
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) start16 = 1'b0;
         if (k == 8) begin
            tests++;
            if (busy16 !== 1'b1 || prod16 !== 32'hFFFE0001) begin
               fails++;
               $display("FAIL w16_hold: busy=%b prod=%h want 1 fffe0001",
                        busy16, prod16);
            end
         end
         if (done16) begin
            n = k;
            break;
         end
      end
      tests++;
      if (prod16 !== 32'h0 || n != 17) begin
         fails++;
         $display("FAIL w16_zero: prod=%h cycles=%0d want 0 17", prod16, n);
      end
   endtask

`ifdef SEQ_MULT_SIGNED_EN
   task automatic test_signed();
      int n;
      sm4 = 1'b1;
      do_mul4(4'h8, 4'h8, n);
      tests++;
      if (prod4 !== 8'h40 || n != 5) begin
         fails++;
         $display("FAIL s_m8xm8: prod=%h cycles=%0d want 40 5", prod4, n);
      end
      do_mul4(4'h8, 4'h7, n);
      tests++;
      if (prod4 !== 8'hC8) begin
         fails++;
         $display("FAIL s_m8x7: got %h want c8", prod4);
      end
      do_mul4(4'h7, 4'h8, n);
      tests++;
      if (prod4 !== 8'hC8) begin
         fails++;
         $display("FAIL s_7xm8: got %h want c8", prod4);
      end
      do_mul4(4'hF, 4'h1, n);
      tests++;
      if (prod4 !== 8'hFF) begin
         fails++;
         $display("FAIL s_m1x1: got %h want ff", prod4);
      end
      sm4 = 1'b0;
      do_mul4(4'h8, 4'h8, n);
      tests++;
      if (prod4 !== 8'h40) begin
         fails++;
         $display("FAIL u_8x8: got %h want 40", prod4);
      end
   endtask
`endif

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      start4 = 1'b0;
      a4 = '0;
      b4 = '0;
      start16 = 1'b0;
      a16 = '0;
      b16 = '0;
`ifdef SEQ_MULT_SIGNED_EN
      sm4 = 1'b0;
      sm16 = 1'b0;
`endif
      test_reset();
      test_exhaustive();
      test_busy_start();
      test_reset_mid();
      test_w16();
`ifdef SEQ_MULT_SIGNED_EN
      test_signed();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
